// File: rtl/pe_sched_pkg.sv
// Shared state encoding and width defaults for the PE layer scheduler.
package pe_sched_pkg;

  localparam int LAYER_W_DEF = 3;
  localparam int ACT_W_DEF   = 6;
  localparam int PERF_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/pe_sched_idx_cnt.sv
// Handshaked index counter: after a start pulse it offers indices 0..cnt-1 on valid/ready.
// valid/idx are flops, rise the cycle after start, and hold while ready is low.
module pe_sched_idx_cnt
  import pe_sched_pkg::*;
#(
  parameter int W = ACT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] cnt,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic         last
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] last_idx;

  // Ends at cnt-1, so the largest count never drives idx past its maximum.
  assign last_idx = cnt - ONE;
  assign last     = valid && (idx == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      idx   <= '0;
    end else if (start) begin
      valid <= 1'b1;
      idx   <= '0;
    end else if (valid && ready) begin
      if (last) begin
        valid <= 1'b0;
        idx   <= '0;
      end else begin
        idx <= idx + ONE;
      end
    end
  end

endmodule

// File: rtl/pe_layer_sched.sv
// Per-layer scheduler: load counts, issue activations, drain PEs, write back, repeat per layer.
// Outputs registered; stalls hold valid/idx. Stall counter enabled by PE_SCHED_PERF_EN.
module pe_layer_sched
  import pe_sched_pkg::*;
#(
  parameter int LAYER_W = LAYER_W_DEF,
  parameter int ACT_W   = ACT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_no,
  input  logic [ACT_W-1:0]   in_act_no,
  input  logic [ACT_W-1:0]   out_act_no,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [ACT_W-1:0]   act_idx,
  input  logic               pe_idle,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [ACT_W-1:0]   wb_idx,
  output logic               done,
  output logic [PERF_W-1:0]  perf_stall_cnt
);

  localparam logic [LAYER_W-1:0] LAYER_ONE = {{(LAYER_W-1){1'b0}}, 1'b1};

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [ACT_W-1:0]   in_cnt;
  logic [ACT_W-1:0]   out_cnt;
  logic [LAYER_W-1:0] layer_last;
  logic               act_last;
  logic               wb_last;
  logic               act_go;
  logic               wb_go;
  logic               act_end;
  logic               wb_end;

  assign layer_last = layer_no - LAYER_ONE;
  assign act_end    = act_last && act_ready;
  assign wb_end     = wb_last && wb_ready;
  assign act_go     = (state == ST_LOAD) && (in_act_no != '0);
  assign wb_go      = (state == ST_DRAIN) && pe_idle && (out_cnt != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (layer_no != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD:  state_nxt = (in_act_no != '0) ? ST_ISSUE : ST_DRAIN;
      ST_ISSUE: if (act_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pe_idle) state_nxt = (out_cnt != '0) ? ST_WB : ST_NEXT;
      ST_WB:    if (wb_end) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = (layer_idx == layer_last) ? ST_DONE : ST_LOAD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      layer_idx <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= (state == ST_DONE);
      // Counts are sampled only here, so lookup changes mid-layer are ignored.
      if (state == ST_LOAD) begin
        in_cnt  <= in_act_no;
        out_cnt <= out_act_no;
      end
      if ((state == ST_NEXT) && (state_nxt == ST_LOAD)) begin
        layer_idx <= layer_idx + LAYER_ONE;
      end else if (state == ST_DONE) begin
        layer_idx <= '0;
      end
    end
  end

  pe_sched_idx_cnt #(.W(ACT_W)) u_act_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (act_go),
    .cnt   (in_cnt),
    .ready (act_ready),
    .valid (act_valid),
    .idx   (act_idx),
    .last  (act_last)
  );

  pe_sched_idx_cnt #(.W(ACT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (wb_go),
    .cnt   (out_cnt),
    .ready (wb_ready),
    .valid (wb_valid),
    .idx   (wb_idx),
    .last  (wb_last)
  );

`ifdef PE_SCHED_PERF_EN
  logic [PERF_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (act_valid && !act_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
